// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the fetch/memory-stage port arbiter.
package dmem_arb_pkg;

   localparam int unsigned DEF_ADDR_W  = 10;
   localparam int unsigned DEF_DATA_W  = 64;
   localparam int unsigned DEF_MEM_LAT = 2;
   localparam int unsigned REQ_ADDR_W  = 64;
   localparam int unsigned CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic {
      REQ_I,
      REQ_D
   } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick between fetch and memory stage; a tie goes to the port not served last.
module rr_arb2
   import dmem_arb_pkg::*;
(
   input  logic    i_req_i,
   input  logic    d_req_i,
   input  req_id_t last_i,
   output req_id_t win_o
);

   always_comb begin
      win_o = REQ_I;
      if (i_req_i && d_req_i) begin
         win_o = (last_i == REQ_I) ? REQ_D : REQ_I;
      end else if (d_req_i) begin
         win_o = REQ_D;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported word memory between fetch (read-only) and the memory stage,
// one transaction in flight, fixed memory read latency.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned MEM_LAT = DEF_MEM_LAT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  i_req_i,
   input  logic [REQ_ADDR_W-1:0] i_addr_i,
   output logic                  i_gnt_o,
   output logic                  i_done_o,
   output logic [DATA_W-1:0]     i_rdata_o,
   output logic                  i_err_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [REQ_ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0]     d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_done_o,
   output logic [DATA_W-1:0]     d_rdata_o,
   output logic                  d_err_o,
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_W-1:0]     mem_addr_o,
   output logic [DATA_W-1:0]     mem_wdata_o,
   input  logic [DATA_W-1:0]     mem_rdata_i,
   output logic                  busy_o
);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   req_id_t                 win_q, win_d, last_q, last_d, arb_win;
   logic                    oor_q, oor_d, we_q, we_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [REQ_ADDR_W-1:0]   sel_addr;

   logic                    i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
   logic                    i_done_q, i_done_d, d_done_q, d_done_d;
   logic                    i_err_q, i_err_d, d_err_q, d_err_d;
   logic                    mem_en_q, mem_en_d, mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;
   logic                    busy_q, busy_d;
   logic [DATA_W-1:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic [DATA_W-1:0]       resp_data;
   logic                    resp_i, resp_d;

   rr_arb2 u_rr_arb2 (
      .i_req_i (i_req_i),
      .d_req_i (d_req_i),
      .last_i  (last_q),
      .win_o   (arb_win)
   );

   assign sel_addr  = (arb_win == REQ_D) ? d_addr_i : i_addr_i;
   assign resp_i    = (state_q == RESP) && (win_q == REQ_I);
   assign resp_d    = (state_q == RESP) && (win_q == REQ_D);
   assign resp_data = (oor_q || we_q) ? '0 : mem_rdata_i;

   // State and all registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         win_q       <= REQ_I;
         last_q      <= REQ_I;
         oor_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         i_gnt_q     <= 1'b0;
         d_gnt_q     <= 1'b0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
         i_err_q     <= 1'b0;
         d_err_q     <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         win_q       <= win_d;
         last_q      <= last_d;
         oor_q       <= oor_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         i_gnt_q     <= i_gnt_d;
         d_gnt_q     <= d_gnt_d;
         i_done_q    <= i_done_d;
         d_done_q    <= d_done_d;
         i_err_q     <= i_err_d;
         d_err_q     <= d_err_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   // Next state, latency counter and request latch
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      last_d  = last_q;
      oor_d   = oor_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (i_req_i || d_req_i) begin
               state_d = ISSUE;
               win_d   = arb_win;
               addr_d  = sel_addr[ADDR_W-1:0];
               oor_d   = |sel_addr[REQ_ADDR_W-1:ADDR_W];
               we_d    = (arb_win == REQ_D) && d_we_i;
               wdata_d = (arb_win == REQ_D) ? d_wdata_i : '0;
            end
         end
         ISSUE: begin
            cnt_d = CNT_W'(MEM_LAT - 1);
            if (oor_q || (MEM_LAT == 1)) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            last_d  = win_q;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values for the cycle being entered
   always_comb begin
      i_gnt_d     = 1'b0;
      d_gnt_d     = 1'b0;
      i_done_d    = 1'b0;
      d_done_d    = 1'b0;
      i_err_d     = i_err_q;
      d_err_d     = d_err_q;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      busy_d      = (state_d != IDLE);
      i_rdata_d   = resp_i ? resp_data : i_rdata_q;
      d_rdata_d   = resp_d ? resp_data : d_rdata_q;
      case (state_d)
         ISSUE: begin
            i_gnt_d = (win_d == REQ_I);
            d_gnt_d = (win_d == REQ_D);
            if (!oor_d) begin
               mem_en_d    = 1'b1;
               mem_we_d    = we_d;
               mem_addr_d  = addr_d;
               mem_wdata_d = wdata_d;
            end
         end
         RESP: begin
            if (win_d == REQ_I) begin
               i_done_d = 1'b1;
               i_err_d  = oor_d;
            end else begin
               d_done_d = 1'b1;
               d_err_d  = oor_d;
            end
         end
         default: ;
      endcase
   end

   // Read data arrives in the response cycle itself, so it is forwarded straight through then
   assign i_rdata_o   = resp_i ? resp_data : i_rdata_q;
   assign d_rdata_o   = resp_d ? resp_data : d_rdata_q;
   assign i_gnt_o     = i_gnt_q;
   assign d_gnt_o     = d_gnt_q;
   assign i_done_o    = i_done_q;
   assign d_done_o    = d_done_q;
   assign i_err_o     = i_err_q;
   assign d_err_o     = d_err_q;
   assign mem_en_o    = mem_en_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: three arbiters (memory latency 2, 1, 4), each with its own memory model.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst       [3];
   logic        i_req     [3];
   logic [63:0] i_addr    [3];
   logic        i_gnt     [3];
   logic        i_done    [3];
   logic [63:0] i_rdata   [3];
   logic        i_err     [3];
   logic        d_req     [3];
   logic        d_we      [3];
   logic [63:0] d_addr    [3];
   logic [63:0] d_wdata   [3];
   logic        d_gnt     [3];
   logic        d_done    [3];
   logic [63:0] d_rdata   [3];
   logic        d_err     [3];
   logic        mem_en    [3];
   logic        mem_we    [3];
   logic [9:0]  mem_addr  [3];
   logic [63:0] mem_wdata [3];
   logic [63:0] mem_rdata [3];
   logic        busy      [3];

   int n_chk;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [63:0] mem  [1024];
      logic [63:0] pipe [16];

      dmem_port_arbiter #(.ADDR_W(10), .DATA_W(64), .MEM_LAT(LAT)) u_dut (
         .clk_i       (clk),
         .rst_i       (rst[g]),
         .i_req_i     (i_req[g]),
         .i_addr_i    (i_addr[g]),
         .i_gnt_o     (i_gnt[g]),
         .i_done_o    (i_done[g]),
         .i_rdata_o   (i_rdata[g]),
         .i_err_o     (i_err[g]),
         .d_req_i     (d_req[g]),
         .d_we_i      (d_we[g]),
         .d_addr_i    (d_addr[g]),
         .d_wdata_i   (d_wdata[g]),
         .d_gnt_o     (d_gnt[g]),
         .d_done_o    (d_done[g]),
         .d_rdata_o   (d_rdata[g]),
         .d_err_o     (d_err[g]),
         .mem_en_o    (mem_en[g]),
         .mem_we_o    (mem_we[g]),
         .mem_addr_o  (mem_addr[g]),
         .mem_wdata_o (mem_wdata[g]),
         .mem_rdata_i (mem_rdata[g]),
         .busy_o      (busy[g])
      );

      // Memory: write at the strobe edge, read data valid LAT cycles after the strobe
      always @(posedge clk) begin
         if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
         pipe[0] <= (mem_en[g] && !mem_we[g]) ? mem[mem_addr[g]] : 64'hBAD0_BAD0_BAD0_BAD0;
         for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rdata[g] = pipe[LAT-1];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Entry and exit of every task: 1 time unit after a rising edge
   task automatic do_reset(input int n);
      rst[n]   = 1'b1;
      i_req[n] = 1'b0;
      d_req[n] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[n] = 1'b0;
      check_eq($sformatf("rst%0d_ctl", n),
               64'({busy[n], i_gnt[n], d_gnt[n], i_done[n], d_done[n],
                    i_err[n], d_err[n], mem_en[n], mem_we[n]}), 64'd0);
      check_eq($sformatf("rst%0d_data", n), i_rdata[n] | d_rdata[n] | 64'(mem_addr[n]), 64'd0);
   endtask

   task automatic do_txn(input string tag, input int n, input bit is_d, input bit we,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input bit exp_err,
                         input int exp_done, input int exp_mem);
      int          gnt_c  = -1;
      int          done_c = -1;
      int          gnt_n  = 0;
      int          en_n   = 0;
      int          busy_n = 0;
      logic [63:0] rd     = 'x;
      logic        er     = 1'bx;
      logic        en_we  = 1'bx;
      logic [9:0]  en_adr = 'x;
      logic        g;
      if (is_d) begin
         d_req[n] = 1'b1; d_we[n] = we; d_addr[n] = addr; d_wdata[n] = wd;
      end else begin
         i_req[n] = 1'b1; i_addr[n] = addr;
      end
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         g = is_d ? d_gnt[n] : i_gnt[n];
         if (g) begin
            gnt_n++;
            if (gnt_c < 0) gnt_c = c;
         end
         if (mem_en[n]) begin
            en_n++; en_we = mem_we[n]; en_adr = mem_addr[n];
         end
         if (busy[n]) busy_n++;
         if (is_d ? d_done[n] : i_done[n]) begin
            done_c = c;
            rd = is_d ? d_rdata[n] : i_rdata[n];
            er = is_d ? d_err[n] : i_err[n];
         end
         @(posedge clk); #1;
         if (g) begin
            if (is_d) d_req[n] = 1'b0; else i_req[n] = 1'b0;
         end
         if (done_c >= 0) break;
      end
      i_req[n] = 1'b0;
      d_req[n] = 1'b0;
      check_eq({tag, "_gnt_cyc"},  64'(gnt_c),  64'(1));
      check_eq({tag, "_gnt_n"},    64'(gnt_n),  64'(1));
      check_eq({tag, "_done_cyc"}, 64'(done_c), 64'(exp_done));
      check_eq({tag, "_rdata"},    rd,          exp_rd);
      check_eq({tag, "_err"},      64'(er),     64'(exp_err));
      check_eq({tag, "_mem_en_n"}, 64'(en_n),   64'(exp_mem));
      check_eq({tag, "_busy_n"},   64'(busy_n), 64'(exp_done));
      if (exp_mem != 0) begin
         check_eq({tag, "_mem_we"},   64'(en_we),  64'(we));
         check_eq({tag, "_mem_addr"}, 64'(en_adr), 64'(addr[9:0]));
      end
      check_eq({tag, "_rdata_hold"}, is_d ? d_rdata[n] : i_rdata[n], exp_rd);
      check_eq({tag, "_idle"},       64'(busy[n]), 64'd0);
   endtask

   // Both ports held high: expect D,I,D,I grants every four cycles at latency 2
   task automatic both_held();
      int          k = 0;
      int          gc [4];
      bit          gd [4];
      bit          got_i = 1'b0;
      logic [63:0] ird = 'x;
      for (int j = 0; j < 4; j++) begin gc[j] = -1; gd[j] = 1'b0; end
      i_req[0] = 1'b1; i_addr[0] = 64'd7;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'd9;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (k < 4 && d_gnt[0]) begin gd[k] = 1'b1; gc[k] = c; k++; end
         else if (k < 4 && i_gnt[0]) begin gd[k] = 1'b0; gc[k] = c; k++; end
         if (i_done[0] && !got_i) begin ird = i_rdata[0]; got_i = 1'b1; end
         @(posedge clk); #1;
         if (k == 4) break;
      end
      i_req[0] = 1'b0;
      d_req[0] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!busy[0]) break;
      end
      @(posedge clk); #1;
      check_eq("rr_gnt0_cyc", 64'(gc[0]), 64'(1));
      check_eq("rr_gnt1_cyc", 64'(gc[1]), 64'(5));
      check_eq("rr_gnt2_cyc", 64'(gc[2]), 64'(9));
      check_eq("rr_gnt3_cyc", 64'(gc[3]), 64'(13));
      check_eq("rr_order", 64'({gd[0], gd[1], gd[2], gd[3]}), 64'(4'b1010));
      check_eq("rr_i_rdata", ird, 64'h7777);
   endtask

   // Reset lands in WAIT (cycle 2) of a D read; the pulse train must stop dead
   task automatic reset_in_wait();
      int ev = 0;
      int bz = 0;
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 64'd5;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("rw_gnt_before", 64'(d_gnt[0]), 64'd1);
      @(posedge clk); #1;
      rst[0]   = 1'b1;
      d_req[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      for (int c = 3; c < 9; c++) begin
         @(negedge clk);
         if (d_done[0] || d_gnt[0] || i_done[0] || i_gnt[0]) ev++;
         if (busy[0]) bz++;
         @(posedge clk); #1;
      end
      check_eq("rw_no_pulse", 64'(ev), 64'd0);
      check_eq("rw_busy_low", 64'(bz), 64'd0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      for (int n = 0; n < 3; n++) begin
         rst[n] = 1'b1; i_req[n] = 1'b0; i_addr[n] = '0;
         d_req[n] = 1'b0; d_we[n] = 1'b0; d_addr[n] = '0; d_wdata[n] = '0;
      end
      @(posedge clk); #1;
      for (int n = 0; n < 3; n++) do_reset(n);

      // latency 2
      do_txn("wr5",   0, 1'b1, 1'b1, 64'd5,    64'hDEAD, 64'd0,    1'b0, 3, 1);
      do_txn("rd5",   0, 1'b1, 1'b0, 64'd5,    64'd0,    64'hDEAD, 1'b0, 3, 1);
      do_txn("wr7",   0, 1'b1, 1'b1, 64'd7,    64'h7777, 64'd0,    1'b0, 3, 1);
      do_txn("wr9",   0, 1'b1, 1'b1, 64'd9,    64'h9999, 64'd0,    1'b0, 3, 1);
      do_txn("oor",   0, 1'b1, 1'b0, 64'd1024, 64'd0,    64'd0,    1'b1, 2, 0);
      do_txn("ird7",  0, 1'b0, 1'b0, 64'd7,    64'd0,    64'h7777, 1'b0, 3, 1);
      do_txn("ioor",  0, 1'b0, 1'b0, 64'h1_0000_0003, 64'd0, 64'd0, 1'b1, 2, 0);
      do_txn("ird9",  0, 1'b0, 1'b0, 64'd9,    64'd0,    64'h9999, 1'b0, 3, 1);
      do_reset(0);
      both_held();
      reset_in_wait();
      do_txn("rw_ird5", 0, 1'b0, 1'b0, 64'd5, 64'd0, 64'hDEAD, 1'b0, 3, 1);

      // latency 1
      do_txn("l1_wr", 1, 1'b1, 1'b1, 64'd20, 64'h1234, 64'd0,    1'b0, 2, 1);
      do_txn("l1_rd", 1, 1'b1, 1'b0, 64'd20, 64'd0,    64'h1234, 1'b0, 2, 1);
      do_txn("l1_ir", 1, 1'b0, 1'b0, 64'd20, 64'd0,    64'h1234, 1'b0, 2, 1);

      // latency 4
      do_txn("l4_wr", 2, 1'b1, 1'b1, 64'd1023, 64'hABCD, 64'd0,    1'b0, 5, 1);
      do_txn("l4_rd", 2, 1'b1, 1'b0, 64'd1023, 64'd0,    64'hABCD, 1'b0, 5, 1);
      do_txn("l4_ir", 2, 1'b0, 1'b0, 64'd1023, 64'd0,    64'hABCD, 1'b0, 5, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
